des_round_key_sequencer: RTL and testbench

- Sits between the DES key generator and an iterative DES round engine.
- On request, it snapshots the 16-round key bus and serves one 48-bit round key per handshake to the round engine.
- Keys are served in ascending order (1..16) for encryption or descending order (16..1) for decryption.
- It frees the key generator bus for reloading while a block is processed and hides key ordering from the round engine.

---
 rtl/des_round_key_sequencer.sv | 172 +++++++++++++++++
 tb/tb_des_round_key_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_key_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_key_sequencer
//
// Purpose:
//   Sits between the DES key generator and an iterative DES round engine.
//   On an accepted start request it snapshots the full round-key bus, which
//   frees the generator to reload. It then serves one round key per
//   valid/ready handshake. Keys go out in ascending order (1..16) for
//   encryption and in descending order (16..1) for decryption, so the round
//   engine never has to know the key order.
//
// Ports:
//   i_clk        clock; all logic runs on the rising edge
//   i_rst        synchronous reset, active-high
//   i_rk         round-key bus [0:767]; round n is bits 48*(n-1) .. 48*n-1
//   i_generated  level; high while i_rk is valid
//   i_start      single-cycle request to begin a key sequence
//   i_decrypt    sampled with i_start; 0 = order 1..16, 1 = order 16..1
//   i_abort      cancels the sequence in progress; also blocks a start in IDLE
//   i_key_ready  the round engine accepts o_key this cycle
//   o_key        current round key [0:47]; holds its value when not valid
//   o_key_valid  o_key holds a valid key
//   o_round      round number of o_key minus 1, in natural numbering
//   o_last       high with o_key_valid when o_key is the final key
//   o_busy       a sequence is in progress
//   o_done       one-cycle pulse after the final transfer
//   o_err        one-cycle pulse when a start is rejected (no valid keys)
// -----------------------------------------------------------------------------
module des_round_key_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_W      = 48
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [0:NUM_ROUNDS*KEY_W-1]     i_rk,
  input  logic                            i_generated,
  input  logic                            i_start,
  input  logic                            i_decrypt,
  input  logic                            i_abort,
  input  logic                            i_key_ready,
  output logic [0:KEY_W-1]                o_key,
  output logic                            o_key_valid,
  output logic [$clog2(NUM_ROUNDS)-1:0]   o_round,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int IDX_W  = $clog2(NUM_ROUNDS);
  localparam int SNAP_W = NUM_ROUNDS * KEY_W;
  localparam int BASE_W = $clog2(SNAP_W);

  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(NUM_ROUNDS - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [0:SNAP_W-1]     r_snap;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_dec;
  logic                  r_done;
  logic                  r_err;

  logic                  w_streaming;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_xfer;
  logic [BASE_W-1:0]     w_base;

  // ---------------------------------------------------------------------------
  // Decode of the current cycle's events
  // ---------------------------------------------------------------------------
  assign w_streaming = (r_state == S_STREAM);

  // The final key is the top index when encrypting and index 0 when
  // decrypting; the index is therefore never stepped past either end.
  assign w_last = w_streaming && (r_idx == (r_dec ? FIRST_IDX : FINAL_IDX));

  // Abort dominates both a start in IDLE and a transfer in STREAM.
  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort &&  i_generated;
  assign w_reject = (r_state == S_IDLE) && i_start && !i_abort && !i_generated;
  assign w_xfer   = w_streaming && i_key_ready && !i_abort;

  // Bit offset of the selected key inside the snapshot.
  assign w_base = BASE_W'(r_idx) * BASE_W'(KEY_W);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; any path that skipped it would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_abort || (w_xfer && w_last)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot, index and status pulses
  // ---------------------------------------------------------------------------
  // NOTE: the 768-bit snapshot is cleared on reset on purpose, so that o_key
  // reads as zero after reset instead of exposing stale key material.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_dec  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      r_err  <= w_reject;

      if (w_accept) begin
        r_snap <= i_rk;
        r_dec  <= i_decrypt;
        r_idx  <= i_decrypt ? FINAL_IDX : FIRST_IDX;
      end else if (w_xfer && !w_last) begin
        r_idx  <= r_dec ? (r_idx - 1'b1) : (r_idx + 1'b1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // o_key is read straight from the snapshot. Index and snapshot only change
  // on an accepted start or a transfer, so the key holds through stalls and
  // after the sequence ends.
  always_comb begin
    o_key       = r_snap[w_base +: KEY_W];
    o_key_valid = w_streaming;
    o_busy      = w_streaming;
    o_round     = r_idx;
    o_last      = w_last;
    o_done      = r_done;
    o_err       = r_err;
  end

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_round_key_sequencer
//
// Self-checking bench for des_round_key_sequencer. The reference model works
// at transaction level. An accepted start copies the sixteen keys into an
// array and builds a queue of round numbers in the order they are to be
// served. Each handshake pops one entry. The expected outputs are read from
// the head of the queue.
// -----------------------------------------------------------------------------
module tb_des_round_key_sequencer;

  localparam int NR = 16;
  localparam int KW = 48;

  logic              clk;
  logic              rst;
  logic [0:NR*KW-1]  rk;
  logic              gen;
  logic              start;
  logic              decrypt;
  logic              abort;
  logic              ready;

  logic [0:KW-1]     o_key;
  logic              o_key_valid;
  logic [3:0]        o_round;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  des_round_key_sequencer #(.NUM_ROUNDS(NR), .KEY_W(KW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rk        (rk),
    .i_generated (gen),
    .i_start     (start),
    .i_decrypt   (decrypt),
    .i_abort     (abort),
    .i_key_ready (ready),
    .o_key       (o_key),
    .o_key_valid (o_key_valid),
    .o_round     (o_round),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  logic [KW-1:0] m_snap [NR];
  int            m_q [$];
  bit            m_active;
  logic [KW-1:0] m_key;
  logic [3:0]    m_round;
  bit            m_done;
  bit            m_err;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Applies the spec rules to the inputs present at this clock edge.
  task automatic model_edge();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      foreach (m_snap[r]) m_snap[r] = '0;
      m_key   = '0;
      m_round = '0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else if (ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start && !abort) begin
      if (gen) begin
        for (int r = 0; r < NR; r++) m_snap[r] = rk[KW*r +: KW];
        m_q.delete();
        for (int r = 0; r < NR; r++) m_q.push_back(decrypt ? (NR - 1 - r) : r);
        m_active = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_active) begin
      m_key   = m_snap[m_q[0]];
      m_round = 4'(m_q[0]);
    end
  endtask

  task automatic compare_all();
    check("key_valid", 64'(o_key_valid), 64'(m_active));
    check("busy",      64'(o_busy),      64'(m_active));
    check("last",      64'(o_last),      64'(m_active && m_q.size() == 1));
    check("done",      64'(o_done),      64'(m_done));
    check("err",       64'(o_err),       64'(m_err));
    check("key",       64'(o_key),       64'(m_key));
    if (m_active) check("round", 64'(o_round), 64'(m_round));
  endtask

  // One clock: the edge, the model update, then sampling 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load_pattern();
    for (int n = 1; n <= NR; n++) rk[KW*(n-1) +: KW] = KW'(n);
  endtask

  task automatic load_random();
    for (int w = 0; w < NR*KW/32; w++) rk[32*w +: 32] = $urandom;
  endtask

  // Steps until DONE is seen and returns the number of cycles counted from
  // the start edge (the start edge counts as 1). The wait is bounded.
  task automatic run_to_done(input int already, output int cycles);
    cycles = already;
    while (!o_done && cycles < 60) begin
      step();
      cycles++;
    end
    check("done_timeout", 64'(o_done), 64'd1);
  endtask

  task automatic pulse_start(input bit dec);
    start   = 1'b1;
    decrypt = dec;
    step();
    start   = 1'b0;
  endtask

  int cycles;

  initial begin
    rst = 1'b1; rk = '0; gen = 1'b0; start = 1'b0; decrypt = 1'b0;
    abort = 1'b0; ready = 1'b0;
    m_active = 1'b0; m_key = '0; m_round = '0; m_done = 1'b0; m_err = 1'b0;
    foreach (m_snap[r]) m_snap[r] = '0;

    // Reset state
    step();
    step();
    check("reset_round", 64'(o_round), 64'd0);
    check("reset_key",   64'(o_key),   64'd0);
    rst = 1'b0;
    step();

    // 1: encrypt, ready held high, DONE 17 cycles after START
    load_pattern();
    gen = 1'b1; ready = 1'b1;
    pulse_start(1'b0);
    check("enc_first_key", 64'(o_key), 64'h01);
    run_to_done(1, cycles);
    check("enc_done_latency", 64'(cycles), 64'd17);
    check("enc_busy_at_done", 64'(o_busy), 64'd0);
    step();

    // 2: decrypt, 16..1
    pulse_start(1'b1);
    check("dec_first_key",   64'(o_key),   64'h10);
    check("dec_first_round", 64'(o_round), 64'd15);
    run_to_done(1, cycles);
    check("dec_done_latency", 64'(cycles), 64'd17);
    check("dec_final_key", 64'(o_key), 64'h01);
    step();
    check("dec_single_done", 64'(o_done), 64'd0);

    // 3: stall for 3 cycles after the 3rd transfer
    pulse_start(1'b0);
    repeat (3) step();
    ready = 1'b0;
    repeat (3) begin
      step();
      check("stall_key",   64'(o_key),   64'h04);
      check("stall_round", 64'(o_round), 64'd3);
    end
    ready = 1'b1;
    run_to_done(7, cycles);
    check("stall_done_latency", 64'(cycles), 64'd20);
    step();

    // 4: start without valid keys, then a normal sequence
    gen = 1'b0;
    pulse_start(1'b0);
    check("err_pulse", 64'(o_err), 64'd1);
    step();
    check("err_one_cycle", 64'(o_err), 64'd0);
    gen = 1'b1;
    pulse_start(1'b0);
    run_to_done(1, cycles);
    check("after_err_latency", 64'(cycles), 64'd17);

    // 5: abort on key 05 with a coincident handshake, then restart
    pulse_start(1'b0);
    repeat (4) step();
    check("abort_on_key5", 64'(o_key), 64'h05);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 64'(o_key_valid), 64'd0);
    repeat (3) step();
    pulse_start(1'b0);
    check("restart_key", 64'(o_key), 64'h01);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_key",   64'(o_key),   64'd0);
    check("rst_round", 64'(o_round), 64'd0);
    step();

    // 6: snapshot isolation and a start ignored mid-stream
    load_pattern();
    pulse_start(1'b0);
    repeat (2) step();
    rk = '1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("midstream_no_err", 64'(o_err), 64'd0);
    run_to_done(5, cycles);
    check("iso_done_latency", 64'(cycles), 64'd17);
    check("iso_final_key", 64'(o_key), 64'h10);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      abort   = ($urandom_range(0, 15) == 0);
      start   = ($urandom_range(0, 3) == 0);
      gen     = ($urandom_range(0, 3) != 0);
      decrypt = 1'($urandom_range(0, 1));
      ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) load_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
